// File: rtl/fifo_frame_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_frame_writer_pkg
//  Purpose  : Shared types and helpers for the frame writer: FSM state
//             encoding, position of the {last} flag in a FIFO word, and the
//             width of the in-frame sample index.
//  Revision : 1.0  initial release
// ============================================================================
package fifo_frame_writer_pkg;

    // Frame writer FSM states, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_STREAM = 2'd2,
        ST_DROP   = 2'd3
    } state_t;

    // The {last} flag sits directly above the sample bits: LAST_BIT = SAMPLE_W.
    function automatic int last_bit_of(input int sample_w);
        return sample_w;
    endfunction

    // Sample index width: $clog2(FRAME_LEN) (FRAME_LEN >= 2, so never 0).
    function automatic int idx_w_of(input int frame_len);
        return $clog2(frame_len);
    endfunction

endpackage : fifo_frame_writer_pkg
`default_nettype wire

// File: rtl/frame_space_check.sv
`default_nettype none
// ============================================================================
//  Module   : frame_space_check
//  Purpose  : Combinational admit decision for a new frame. Computes the FIFO
//             free space, minus the writes still in flight towards
//             fifo_count, and compares it with the frame length.
//  Ports    : fifo_full  in   FIFO full flag (count has wrapped to 0 when set)
//             fifo_count in   write-domain fill count
//             admit      out  1 when a whole frame fits
//  Revision : 1.0  initial release
// ============================================================================
module frame_space_check #(
    parameter int DEPTH_W    = 10,
    parameter int FRAME_LEN  = 256,
    parameter int LAT_MARGIN = 2
) (
    input  logic               fifo_full,
    input  logic [DEPTH_W-1:0] fifo_count,
    output logic               admit
);

    // One extra bit beyond DEPTH_W+1 gives a sign bit, so that
    // depth - count - margin can go negative without wrapping.
    localparam logic signed [DEPTH_W+1:0] c_depth     = (DEPTH_W+2)'(2**DEPTH_W);
    localparam logic signed [DEPTH_W+1:0] c_margin    = (DEPTH_W+2)'(LAT_MARGIN);
    localparam logic        [DEPTH_W:0]   c_frame_len = (DEPTH_W+1)'(FRAME_LEN);

    logic signed [DEPTH_W+1:0] w_diff;
    logic        [DEPTH_W:0]   w_space;

    assign w_diff = c_depth - $signed({2'b00, fifo_count}) - c_margin;

    always_comb begin
        w_space = '0;
        // fifo_count reads 0 when full, so the full flag must override it.
        if (!fifo_full && !w_diff[DEPTH_W+1]) begin
            w_space = w_diff[DEPTH_W:0];
        end
    end

    assign admit = (w_space >= c_frame_len);

endmodule : frame_space_check
`default_nettype wire

// File: rtl/fifo_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_frame_writer
//  Purpose  : Write-side producer for the audio async FIFO (clk_write domain).
//             Pushes samples as whole frames of FRAME_LEN words {last, sample};
//             a frame that does not fit is dropped in full so the reader never
//             sees a partial frame.
//  Ports    : clk_write, rst_n (async, active-low)
//             enable, sample_valid, sample_data     - sample stream in
//             fifo_full, fifo_count                 - FIFO write-side status
//             clear_ovf                             - clears overflow
//             fifo_write, fifo_data                 - FIFO write port
//             frame_done, overflow, drop_count      - status
//  Config   : FRAME_WRITER_STATS_EN - when defined, drop_count is a saturating
//             16-bit dropped-frame counter; otherwise it is tied to 0.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_frame_writer
    import fifo_frame_writer_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int DEPTH_W    = 10,
    parameter int FRAME_LEN  = 256,
    parameter int LAT_MARGIN = 2
) (
    input  logic                clk_write,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                fifo_full,
    input  logic [DEPTH_W-1:0]  fifo_count,
    input  logic                clear_ovf,
    output logic                fifo_write,
    output logic [SAMPLE_W:0]   fifo_data,
    output logic                frame_done,
    output logic                overflow,
    output logic [15:0]         drop_count
);

    localparam int LAST_BIT = last_bit_of(SAMPLE_W);
    localparam int IDX_W    = idx_w_of(FRAME_LEN);

    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);

    state_t              r_state;
    state_t              w_state_next;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_next;

    logic                w_admit;
    logic                w_write;
    logic                w_last;
    logic                w_drop;        // frame rejected at its first sample
    logic                w_ovf_set;
    logic                w_frame_end;   // last index consumed in STREAM or DROP

    logic                r_fifo_write;
    logic [SAMPLE_W:0]   r_fifo_data;
    logic                r_frame_done;
    logic                r_overflow;

    frame_space_check #(
        .DEPTH_W    (DEPTH_W),
        .FRAME_LEN  (FRAME_LEN),
        .LAT_MARGIN (LAT_MARGIN)
    ) u_space_check (
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .admit      (w_admit)
    );

    // ------------------------------------------------------------------
    // State and index registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) w_state_next = ST_ARM;
            end
            ST_ARM: begin
                // Losing enable before a frame starts returns to IDLE even if
                // a sample is present: no new frame may begin.
                if (!enable)          w_state_next = ST_IDLE;
                else if (sample_valid) w_state_next = w_admit ? ST_STREAM : ST_DROP;
            end
            ST_STREAM, ST_DROP: begin
                // A started frame always runs to completion; enable only
                // decides where to go afterwards.
                if (w_frame_end) w_state_next = enable ? ST_ARM : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-cycle actions
    // ------------------------------------------------------------------
    always_comb begin
        w_write     = 1'b0;
        w_last      = 1'b0;
        w_drop      = 1'b0;
        w_ovf_set   = 1'b0;
        w_frame_end = 1'b0;
        w_idx_next  = r_idx;
        case (r_state)
            ST_ARM: begin
                // The admit check runs on the same cycle as the first sample;
                // LAT_MARGIN covers the previous frame's writes not yet in
                // fifo_count.
                if (enable && sample_valid) begin
                    w_write    = w_admit;
                    w_drop     = !w_admit;
                    w_ovf_set  = !w_admit;
                    w_idx_next = c_idx_one;
                end
            end
            ST_STREAM: begin
                if (sample_valid) begin
                    // A full FIFO here should never happen; the word is lost
                    // but the index keeps advancing to preserve alignment.
                    w_write     = !fifo_full;
                    w_ovf_set   = fifo_full;
                    w_last      = (r_idx == c_idx_last);
                    w_frame_end = w_last;
                    w_idx_next  = w_last ? '0 : r_idx + c_idx_one;
                end
            end
            ST_DROP: begin
                if (sample_valid) begin
                    w_frame_end = (r_idx == c_idx_last);
                    w_idx_next  = w_frame_end ? '0 : r_idx + c_idx_one;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers (one cycle from sample_valid to fifo_write)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_write <= 1'b0;
            r_fifo_data  <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_fifo_write <= w_write;
            r_frame_done <= w_write && w_last;
            if (w_write) begin
                r_fifo_data[LAST_BIT]     <= w_last;
                r_fifo_data[LAST_BIT-1:0] <= sample_data;
            end
            // Setting wins over a simultaneous clear.
            if (w_ovf_set)      r_overflow <= 1'b1;
            else if (clear_ovf) r_overflow <= 1'b0;
        end
    end

    assign fifo_write = r_fifo_write;
    assign fifo_data  = r_fifo_data;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

`ifdef FRAME_WRITER_STATS_EN
    logic [15:0] r_drop_count;

    // Saturating; cleared only by reset.
    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = '0;
`endif

endmodule : fifo_frame_writer
`default_nettype wire

// File: tb/tb_fifo_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_frame_writer
//  Purpose  : Scoreboard bench for fifo_frame_writer (SAMPLE_W=16, DEPTH_W=4,
//             FRAME_LEN=8, LAT_MARGIN=2). The driver pushes expected FIFO
//             words with their due cycle; a monitor pops and compares on every
//             fifo_write.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_frame_writer;

    localparam int SW = 16;
    localparam int DW = 4;
    localparam int FL = 8;
    localparam int LM = 2;

    logic          clk_write = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          sample_valid;
    logic [SW-1:0] sample_data;
    logic          fifo_full;
    logic [DW-1:0] fifo_count;
    logic          clear_ovf;
    logic          fifo_write;
    logic [SW:0]   fifo_data;
    logic          frame_done;
    logic          overflow;
    logic [15:0]   drop_count;

    always #5 clk_write = ~clk_write;

    fifo_frame_writer #(
        .SAMPLE_W   (SW),
        .DEPTH_W    (DW),
        .FRAME_LEN  (FL),
        .LAT_MARGIN (LM)
    ) dut (
        .clk_write    (clk_write),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .fifo_full    (fifo_full),
        .fifo_count   (fifo_count),
        .clear_ovf    (clear_ovf),
        .fifo_write   (fifo_write),
        .fifo_data    (fifo_data),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    typedef struct {
        logic [SW:0] word;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk_write) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] exp_drops(input int n);
`ifdef FRAME_WRITER_STATS_EN
        return 16'(n);
`else
        return (n == 0) ? 16'd0 : 16'd0;
`endif
    endfunction

    // Monitor: every write must match the oldest expected word, on its due cycle.
    exp_t mon_e;
    always @(negedge clk_write) begin
        if (fifo_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got data 0x%0h expected no write (cycle %0d)", fifo_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_data", 32'(fifo_data), 32'(mon_e.word));
                check("write_latency", cyc, mon_e.cyc);
                check("frame_done", 32'(frame_done), 32'(mon_e.word[SW]));
            end
        end else if (frame_done !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL stray_frame_done: got %b expected 0 (cycle %0d)", frame_done, cyc);
        end
    end

    // Drive one frame of FL samples; dis_after drops enable with that sample index.
    task automatic send_frame(input int base, input bit accept, input int dis_after, input bit clr_first);
        for (int i = 0; i < FL; i++) begin
            @(negedge clk_write);
            sample_valid = 1'b1;
            sample_data  = SW'(base + i);
            if (i == dis_after) enable = 1'b0;
            clear_ovf = clr_first && (i == 0);
            if (accept) begin
                exp_t e;
                e.word = {(i == FL - 1), SW'(base + i)};
                e.cyc  = cyc + 1;
                exp_q.push_back(e);
            end
        end
        @(negedge clk_write);
        sample_valid = 1'b0;
        clear_ovf    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_write);
    endtask

    task automatic pulse_clear();
        clear_ovf = 1'b1;
        @(negedge clk_write);
        clear_ovf = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        fifo_full    = 1'b0;
        fifo_count   = '0;
        clear_ovf    = 1'b0;

        // Reset state
        idle(3);
        check("reset_fifo_write", 32'(fifo_write), 0);
        check("reset_fifo_data", 32'(fifo_data), 0);
        check("reset_frame_done", 32'(frame_done), 0);
        check("reset_overflow", 32'(overflow), 0);
        check("reset_drop_count", 32'(drop_count), 0);
        rst_n = 1'b1;

        // 1: basic frame from an empty FIFO
        @(negedge clk_write);
        enable = 1'b1;
        send_frame(1, 1'b1, -1, 1'b0);
        idle(2);
        check("t1_overflow", 32'(overflow), 0);

        // 2: boundary space=8 admits, space=7 drops, then recovery
        fifo_count = 4'd6;
        send_frame(16'h10, 1'b1, -1, 1'b0);
        fifo_count = 4'd7;
        send_frame(16'h20, 1'b0, -1, 1'b0);
        idle(1);
        check("t2_overflow", 32'(overflow), 1);
        check("t2_drop_count", 32'(drop_count), 32'(exp_drops(1)));
        fifo_count = 4'd0;
        send_frame(16'h30, 1'b1, -1, 1'b0);

        // 3: full flag with wrapped count drops the frame
        pulse_clear();
        check("t3_cleared", 32'(overflow), 0);
        fifo_full = 1'b1;
        send_frame(16'h40, 1'b0, -1, 1'b0);
        fifo_full = 1'b0;
        idle(1);
        check("t3_overflow", 32'(overflow), 1);
        check("t3_drop_count", 32'(drop_count), 32'(exp_drops(2)));

        // 4: enable falls with the 4th sample; frame completes, then IDLE ignores samples
        pulse_clear();
        check("t4_cleared", 32'(overflow), 0);
        send_frame(16'h50, 1'b1, 3, 1'b0);
        send_frame(16'h60, 1'b0, -1, 1'b0);
        idle(2);
        check("t4_overflow", 32'(overflow), 0);
        check("t4_drop_count", 32'(drop_count), 32'(exp_drops(2)));

        // 5: reset after the 4th sample of a frame
        enable = 1'b1;
        @(negedge clk_write);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            @(negedge clk_write);
            sample_valid = 1'b1;
            sample_data  = SW'(16'h70 + i);
            e.word = {1'b0, SW'(16'h70 + i)};
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk_write);
        sample_valid = 1'b0;
        @(negedge clk_write);
        rst_n = 1'b0;
        #1;
        check("t5_write_in_reset", 32'(fifo_write), 0);
        @(negedge clk_write);
        check("t5_write_in_reset2", 32'(fifo_write), 0);
        check("t5_drop_count_reset", 32'(drop_count), 0);
        rst_n = 1'b1;
        send_frame(16'h80, 1'b1, -1, 1'b0);

        // 6: clear_ovf coincident with a drop loses to the set
        fifo_count = 4'd7;
        send_frame(16'h90, 1'b0, -1, 1'b1);
        idle(1);
        check("t6_set_wins", 32'(overflow), 1);
        check("t6_drop_count", 32'(drop_count), 32'(exp_drops(1)));
        pulse_clear();
        check("t6_cleared", 32'(overflow), 0);

        idle(3);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo_frame_writer
`default_nettype wire
